// File: rtl/msdap_tx_pkg.sv
// Purpose: shared types for the MSDAP serial transmitter (FSM states, sample pair).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package msdap_tx_pkg;

    localparam int MSDAP_WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } tx_state_t;

    typedef struct packed {
        logic [MSDAP_WORD_W-1:0] l;
        logic [MSDAP_WORD_W-1:0] r;
    } sample_pair_t;

endpackage

// File: rtl/msdap_tx_fifo.sv
// Purpose: small synchronous FIFO of left/right sample pairs.
// Latency: a push is visible at head_dat / count after one DCLK edge.
// Backpressure: full blocks pushes; flush empties the FIFO and drops a same-cycle push/pop.
// Ports: DCLK/Reset_n clock and async active-low reset; push/push_dat write side;
//        pop/head_dat read side (head is valid whenever !empty); flush; full, empty, count.
module msdap_tx_fifo
    import msdap_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     DCLK,
    input  logic                     Reset_n,
    input  logic                     push,
    input  sample_pair_t             push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output sample_pair_t             head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    sample_pair_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];

    // flush wins over everything in its cycle
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge DCLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge DCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/msdap_serial_tx.sv
// Purpose: buffers L/R sample pairs and sends them MSB first on Frame/InputL/InputR.
// Latency: pair pushed into an empty FIFO at edge k (idle, InReady=1) shows Frame after edge k+1.
// Backpressure: word_ready drops while the FIFO is full; InReady is honoured only at word boundaries.
// Ports: DCLK, Reset_n (async active-low); word_valid/word_ready/word_l/word_r host side;
//        flush; InReady; Frame/InputL/InputR serial line; busy, fifo_count, words_sent status.
//        WORD_W must equal MSDAP_WORD_W because the FIFO stores sample_pair_t.
module msdap_serial_tx
    import msdap_tx_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                          DCLK,
    input  logic                          Reset_n,
    input  logic                          word_valid,
    output logic                          word_ready,
    input  logic [WORD_W-1:0]             word_l,
    input  logic [WORD_W-1:0]             word_r,
    input  logic                          flush,
    input  logic                          InReady,
    output logic                          Frame,
    output logic                          InputL,
    output logic                          InputR,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   words_sent
);

    localparam int BW    = $clog2(WORD_W);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_state_t          state, state_nxt;
    logic [WORD_W-1:0]  shift_l, shift_l_nxt;
    logic [WORD_W-1:0]  shift_r, shift_r_nxt;
    logic [BW-1:0]      bit_cnt, bit_cnt_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
    logic               frame_nxt, in_l_nxt, in_r_nxt;
    logic [15:0]        words_sent_nxt;

    sample_pair_t       head_dat;
    logic               fifo_full, fifo_empty;
    logic               pop, launch, launch_ok;

    msdap_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .DCLK     (DCLK),
        .Reset_n  (Reset_n),
        .push     (word_valid),
        .push_dat ('{l: word_l, r: word_r}),
        .pop      (pop),
        .flush    (flush),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign word_ready = !fifo_full;
    assign busy       = (state != IDLE) || !fifo_empty;
    // a flush in the boundary cycle suppresses the launch so pop never races the discard
    assign launch_ok  = !fifo_empty && InReady && !flush;

    always_comb begin
        state_nxt      = state;
        shift_l_nxt    = shift_l;
        shift_r_nxt    = shift_r;
        bit_cnt_nxt    = bit_cnt;
        gap_cnt_nxt    = gap_cnt;
        words_sent_nxt = words_sent;
        frame_nxt      = 1'b0;
        in_l_nxt       = 1'b0;
        in_r_nxt       = 1'b0;
        launch         = 1'b0;

        case (state)
            IDLE: begin
                launch = launch_ok;
            end
            SHIFT: begin
                if (bit_cnt != '0) begin
                    // shift_l[WORD_W-1] is already on the line; present the next bit
                    shift_l_nxt = shift_l << 1;
                    shift_r_nxt = shift_r << 1;
                    in_l_nxt    = shift_l[WORD_W-2];
                    in_r_nxt    = shift_r[WORD_W-2];
                    bit_cnt_nxt = bit_cnt - BW'(1);
                end else begin
                    words_sent_nxt = words_sent + 16'd1;
                    if (GAP_CYCLES > 0) begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = GAP_W'(GAP_CYCLES - 1);
                    end else if (launch_ok) begin
                        launch = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt != '0) begin
                    gap_cnt_nxt = gap_cnt - GAP_W'(1);
                end else if (launch_ok) begin
                    launch = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (launch) begin
            shift_l_nxt = head_dat.l;
            shift_r_nxt = head_dat.r;
            frame_nxt   = 1'b1;
            in_l_nxt    = head_dat.l[WORD_W-1];
            in_r_nxt    = head_dat.r[WORD_W-1];
            bit_cnt_nxt = BW'(WORD_W - 1);
            state_nxt   = SHIFT;
        end
        pop = launch;
    end

    always_ff @(posedge DCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            shift_l    <= '0;
            shift_r    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            Frame      <= 1'b0;
            InputL     <= 1'b0;
            InputR     <= 1'b0;
            words_sent <= '0;
        end else begin
            state      <= state_nxt;
            shift_l    <= shift_l_nxt;
            shift_r    <= shift_r_nxt;
            bit_cnt    <= bit_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            Frame      <= frame_nxt;
            InputL     <= in_l_nxt;
            InputR     <= in_r_nxt;
            words_sent <= words_sent_nxt;
        end
    end

endmodule

// File: tb/tb_msdap_serial_tx.sv
// Purpose: self-checking bench for msdap_serial_tx (gap 0 and gap 2 instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_msdap_serial_tx;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          DCLK    = 1'b0;
    logic          Reset_n = 1'b1;
    logic          v0      = 1'b0;
    logic          vg      = 1'b0;
    logic [W-1:0]  word_l  = '0;
    logic [W-1:0]  word_r  = '0;
    logic          flush   = 1'b0;
    logic          InReady = 1'b0;

    logic          rdy0, frame0, il0, ir0, busy0;
    logic [CW-1:0] cnt0;
    logic [15:0]   ws0;
    logic          rdyg, frameg, ilg, irg, busyg;
    logic [CW-1:0] cntg;
    logic [15:0]   wsg;

    always #5 DCLK = ~DCLK;

    msdap_serial_tx #(.WORD_W(W), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(0)) dut0 (
        .DCLK(DCLK), .Reset_n(Reset_n), .word_valid(v0), .word_ready(rdy0),
        .word_l(word_l), .word_r(word_r), .flush(flush), .InReady(InReady),
        .Frame(frame0), .InputL(il0), .InputR(ir0), .busy(busy0),
        .fifo_count(cnt0), .words_sent(ws0)
    );

    msdap_serial_tx #(.WORD_W(W), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(2)) dutg (
        .DCLK(DCLK), .Reset_n(Reset_n), .word_valid(vg), .word_ready(rdyg),
        .word_l(word_l), .word_r(word_r), .flush(flush), .InReady(InReady),
        .Frame(frameg), .InputL(ilg), .InputR(irg), .busy(busyg),
        .fifo_count(cntg), .words_sent(wsg)
    );

    // which instance the model is following: 0 -> gap 0, 1 -> gap 2
    int act = 0;

    logic          o_rdy, o_frame, o_l, o_r, o_busy;
    logic [CW-1:0] o_cnt;
    logic [15:0]   o_ws;
    assign o_rdy   = (act != 0) ? rdyg   : rdy0;
    assign o_frame = (act != 0) ? frameg : frame0;
    assign o_l     = (act != 0) ? ilg    : il0;
    assign o_r     = (act != 0) ? irg    : ir0;
    assign o_busy  = (act != 0) ? busyg  : busy0;
    assign o_cnt   = (act != 0) ? cntg   : cnt0;
    assign o_ws    = (act != 0) ? wsg    : ws0;

    int checks   = 0;
    int failures = 0;

    // reference model: queued pairs, word currently on the line, gap cycles left
    logic [31:0] mq [$];
    logic [31:0] cur;
    int          rem;
    int          gap;
    int          ws;
    int          cyc;
    int          frame_cyc [$];
    int          peak;
    logic [W-1:0] rxl, rxr;
    int          rxn;
    int          rx_words;
    logic [31:0] last_rx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        cur = '0;
        rem = 0;
        gap = 0;
        ws  = 0;
        rxn = 0;
    endtask

    task automatic tick();
        logic        acc;
        logic        launch;
        logic        slot;
        logic [15:0] ml, mr;
        int          g;
        g   = (act != 0) ? 2 : 0;
        acc = ((act != 0) ? vg : v0) && (mq.size() != DEPTH);
        @(posedge DCLK);
        #1;
        cyc++;
        if (!Reset_n) begin
            model_reset();
        end else begin
            slot   = (rem == 1 && g == 0) || (rem == 0 && gap <= 1);
            launch = slot && (mq.size() > 0) && InReady && !flush;
            if (rem == 1) ws = (ws + 1) % 65536;
            if (launch) begin
                cur = mq.pop_front();
                rem = W;
                gap = 0;
            end else if (rem > 1) begin
                rem--;
            end else if (rem == 1) begin
                rem = 0;
                gap = g;
            end else if (gap > 0) begin
                gap--;
            end
            if (flush)    mq.delete();
            else if (acc) mq.push_back({word_l, word_r});

            // independent deserializer of the line
            if (o_frame) begin
                rxl = {15'b0, o_l};
                rxr = {15'b0, o_r};
                rxn = 1;
                frame_cyc.push_back(cyc);
            end else if (rxn > 0 && rxn < W) begin
                rxl = {rxl[W-2:0], o_l};
                rxr = {rxr[W-2:0], o_r};
                rxn++;
            end
            if (rxn == W) begin
                last_rx = {rxl, rxr};
                chk("rx_word", last_rx, cur);
                rxn = 0;
                rx_words++;
            end
        end
        if (int'(o_cnt) > peak) peak = int'(o_cnt);
        ml = cur[31:16];
        mr = cur[15:0];
        chk("frame", o_frame, rem == W);
        chk("input_l", o_l, (rem > 0) ? ml[rem-1] : 1'b0);
        chk("input_r", o_r, (rem > 0) ? mr[rem-1] : 1'b0);
        chk("fifo_count", o_cnt, mq.size());
        chk("words_sent", o_ws, ws);
        chk("busy", o_busy, (rem > 0) || (gap > 0) || (mq.size() > 0));
        chk("word_ready", o_rdy, mq.size() != DEPTH);
    endtask

    task automatic push_one(input logic [15:0] l, input logic [15:0] r);
        if (act != 0) vg = 1'b1; else v0 = 1'b1;
        word_l = l;
        word_r = r;
        tick();
        v0 = 1'b0;
        vg = 1'b0;
    endtask

    task automatic wait_rem(input string tag, input int target);
        for (int i = 0; i < 64 && rem != target; i++) tick();
        chk(tag, rem, target);
    endtask

    task automatic pulse_reset();
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
    endtask

    int ws_before;

    initial begin
        model_reset();
        cyc = 0; peak = 0; rx_words = 0; last_rx = '0; rxl = '0; rxr = '0;
        InReady = 1'b1;

        // reset state, checked before any clock edge
        #1 Reset_n = 1'b0;
        #1;
        chk("rst_frame", frame0, 1'b0);
        chk("rst_inl", il0, 1'b0);
        chk("rst_inr", ir0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_count", cnt0, 0);
        chk("rst_ws", ws0, 0);
        repeat (2) tick();
        Reset_n = 1'b1;
        #1;
        chk("rst_ready", rdy0, 1'b1);

        // 1: single word, latency and bit order
        push_one(16'hA5C3, 16'h0F0F);
        chk("t1_frame_k", o_frame, 1'b0);
        tick();
        chk("t1_frame_k1", o_frame, 1'b1);
        tick();
        chk("t1_frame_one_cycle", o_frame, 1'b0);
        repeat (14) tick();
        chk("t1_serial", last_rx, 32'hA5C30F0F);
        chk("t1_busy_last_bit", o_busy, 1'b1);
        tick();
        chk("t1_busy_low", o_busy, 1'b0);
        chk("t1_ws", o_ws, 1);

        // 2: back-to-back words
        frame_cyc.delete();
        peak = 0;
        for (int i = 0; i < 3; i++) push_one(16'($urandom), 16'($urandom));
        repeat (50) tick();
        chk("t2_frames", frame_cyc.size(), 3);
        if (frame_cyc.size() == 3) begin
            chk("t2_spacing0", frame_cyc[1] - frame_cyc[0], W);
            chk("t2_spacing1", frame_cyc[2] - frame_cyc[1], W);
        end
        chk("t2_ws", o_ws, 4);
        chk("t2_peak", peak, 2);

        // 3: fill with InReady low, fifth push ignored
        InReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_one(16'($urandom), 16'($urandom));
            if (i == 3) chk("t3_ready_full", o_rdy, 1'b0);
        end
        chk("t3_count", o_cnt, 4);
        InReady = 1'b1;
        rx_words = 0;
        repeat (4 * W + 6) tick();
        chk("t3_rx_words", rx_words, 4);
        chk("t3_ws", o_ws, 8);

        // 4: InReady drops at bit 7 with one pair queued
        push_one(16'($urandom), 16'($urandom));
        push_one(16'($urandom), 16'($urandom));
        wait_rem("t4_reach_bit7", 8);
        InReady = 1'b0;
        frame_cyc.delete();
        repeat (30) tick();
        chk("t4_no_frame", frame_cyc.size(), 0);
        chk("t4_ws", o_ws, 9);
        chk("t4_queued", o_cnt, 1);
        InReady = 1'b1;
        tick();
        chk("t4_relaunch", o_frame, 1'b1);
        repeat (20) tick();
        chk("t4_ws_after", o_ws, 10);

        // 5: flush mid-word with three pairs queued
        for (int i = 0; i < 4; i++) push_one(16'($urandom), 16'($urandom));
        chk("t5_queued", o_cnt, 3);
        ws_before = int'(o_ws);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_flushed", o_cnt, 0);
        frame_cyc.delete();
        repeat (30) tick();
        chk("t5_ws_plus1", o_ws, ws_before + 1);
        chk("t5_no_frame", frame_cyc.size(), 0);
        chk("t5_idle", o_busy, 1'b0);

        // 6: asynchronous reset mid-word
        push_one(16'hFFFF, 16'hFFFF);
        wait_rem("t6_reach_bit4", 5);
        #3 Reset_n = 1'b0;
        #1;
        chk("t6_frame", frame0, 1'b0);
        chk("t6_inl", il0, 1'b0);
        chk("t6_inr", ir0, 1'b0);
        chk("t6_count", cnt0, 0);
        chk("t6_ws", ws0, 0);
        model_reset();
        tick();
        Reset_n = 1'b1;

        // gap of two cycles between words
        act = 1;
        frame_cyc.delete();
        for (int i = 0; i < 3; i++) push_one(16'($urandom), 16'($urandom));
        repeat (70) tick();
        chk("g_frames", frame_cyc.size(), 3);
        if (frame_cyc.size() == 3) begin
            chk("g_spacing0", frame_cyc[1] - frame_cyc[0], W + 2);
            chk("g_spacing1", frame_cyc[2] - frame_cyc[1], W + 2);
        end
        chk("g_ws", o_ws, 3);

        // randomized traffic on both instances
        for (int a = 0; a < 2; a++) begin
            act = a;
            pulse_reset();
            for (int i = 0; i < 600; i++) begin
                if (a != 0) vg = ($urandom_range(0, 2) != 0);
                else        v0 = ($urandom_range(0, 2) != 0);
                word_l  = 16'($urandom);
                word_r  = 16'($urandom);
                InReady = ($urandom_range(0, 7) != 0);
                flush   = ($urandom_range(0, 39) == 0);
                tick();
            end
            v0 = 1'b0;
            vg = 1'b0;
            flush = 1'b0;
            InReady = 1'b1;
            repeat (120) tick();
            chk("rand_drained", o_busy, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
